// File: rtl/mem_write_checker.sv
// mem_write_checker: synthesisable monitor for the data-memory write port.
// Compares an ordered list of expected (address, data) writes against the
// observed memwrite/dataadr/writedata stream and reports pass, mismatch or
// timeout, capturing the offending write on a mismatch.
module mem_write_checker #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NUM_EXP  = 8,
  parameter int unsigned TIMEOUT  = 4096,
  parameter bit          IGN_EN   = 1'b1,
  parameter int unsigned IGN_ADDR = 80,
  parameter bit          STRICT   = 1'b1,
  localparam int unsigned IDXW    = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1,
  localparam int unsigned CNTW    = $clog2(NUM_EXP + 1),
  localparam int unsigned CYCW    = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [IDXW-1:0]  cfg_idx,
  input  logic [WIDTH-1:0] cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic             start,
  input  logic [CNTW-1:0]  exp_count,
  input  logic             clear,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] dataadr,
  input  logic [WIDTH-1:0] writedata,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [1:0]       status,
  output logic [CNTW-1:0]  match_cnt,
  output logic [CYCW-1:0]  cycle_cnt,
  output logic [WIDTH-1:0] fail_addr,
  output logic [WIDTH-1:0] fail_data
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RUN  = 3'd1;
  localparam logic [2:0] S_PASS = 3'd2;
  localparam logic [2:0] S_FAIL = 3'd3;
  localparam logic [2:0] S_TMO  = 3'd4;

  localparam logic [WIDTH-1:0] LP_IGN_ADDR = WIDTH'(IGN_ADDR);
  localparam logic [CNTW-1:0]  LP_NUM_EXP  = CNTW'(NUM_EXP);
  localparam logic [CYCW-1:0]  LP_LAST_CYC = CYCW'(TIMEOUT - 1);

  logic [2:0]       r_state;
  logic [WIDTH-1:0] r_tab_addr [NUM_EXP];
  logic [WIDTH-1:0] r_tab_data [NUM_EXP];
  logic [CNTW-1:0]  r_count;
  logic [CNTW-1:0]  r_match_cnt;
  logic [CYCW-1:0]  r_cycle_cnt;
  logic [WIDTH-1:0] r_fail_addr;
  logic [WIDTH-1:0] r_fail_data;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [1:0]       r_status;

  logic [WIDTH-1:0] w_cur_addr;
  logic [WIDTH-1:0] w_cur_data;
  logic [CNTW-1:0]  w_cnt_lat;
  logic [CNTW-1:0]  w_match_inc;
  logic             w_ign;
  logic             w_hit;
  logic             w_miss;
  logic             w_complete;
  logic             w_fail;
  logic             w_last_cyc;
  logic [2:0]       w_state_nxt;

  // Select the table entry currently awaited (index = entries matched so far).
  always_comb begin
    w_cur_addr = '0;
    w_cur_data = '0;
    for (int unsigned i = 0; i < NUM_EXP; i++) begin
      if (CNTW'(i) == r_match_cnt) begin
        w_cur_addr = r_tab_addr[i];
        w_cur_data = r_tab_data[i];
      end
    end
  end

  // Classify the observed write and compute the next state.
  always_comb begin
    w_cnt_lat   = (exp_count > LP_NUM_EXP) ? LP_NUM_EXP : exp_count;
    w_match_inc = r_match_cnt + CNTW'(1);
    // Scratch address is filtered before the table compare so it never matches.
    w_ign       = IGN_EN && (dataadr == LP_IGN_ADDR);
    w_hit       = memwrite && !w_ign && (dataadr == w_cur_addr) && (writedata == w_cur_data);
    w_miss      = memwrite && !w_ign && !w_hit;
    w_complete  = w_hit && (w_match_inc == r_count);
    w_fail      = w_miss && STRICT;
    w_last_cyc  = (r_cycle_cnt == LP_LAST_CYC);
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = (w_cnt_lat == '0) ? S_PASS : S_RUN;
      // Pass/fail on the final cycle take priority over timeout.
      S_RUN: begin
        if (w_complete)      w_state_nxt = S_PASS;
        else if (w_fail)     w_state_nxt = S_FAIL;
        else if (w_last_cyc) w_state_nxt = S_TMO;
      end
      S_PASS, S_FAIL, S_TMO: if (clear) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Expected-write table, writable only while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_EXP; i++) begin
        r_tab_addr[i] <= '0;
        r_tab_data[i] <= '0;
      end
    end else if (r_state == S_IDLE && cfg_we) begin
      for (int unsigned i = 0; i < NUM_EXP; i++) begin
        if (IDXW'(i) == cfg_idx) begin
          r_tab_addr[i] <= cfg_addr;
          r_tab_data[i] <= cfg_data;
        end
      end
    end
  end

  // State, run counters, failure capture and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_match_cnt <= '0;
      r_cycle_cnt <= '0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_status    <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == S_RUN);
      r_done  <= (w_state_nxt == S_PASS) || (w_state_nxt == S_FAIL) || (w_state_nxt == S_TMO);
      r_pass  <= (w_state_nxt == S_PASS);
      case (w_state_nxt)
        S_PASS:  r_status <= 2'd1;
        S_FAIL:  r_status <= 2'd2;
        S_TMO:   r_status <= 2'd3;
        default: r_status <= 2'd0;
      endcase
      if (r_state == S_IDLE && start) begin
        r_count     <= w_cnt_lat;
        r_match_cnt <= '0;
        r_cycle_cnt <= '0;
        r_fail_addr <= '0;
        r_fail_data <= '0;
      end else if (r_state == S_RUN) begin
        r_cycle_cnt <= r_cycle_cnt + CYCW'(1);
        if (w_hit) r_match_cnt <= w_match_inc;
        if (w_fail) begin
          r_fail_addr <= dataadr;
          r_fail_data <= writedata;
        end
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign status    = r_status;
  assign match_cnt = r_match_cnt;
  assign cycle_cnt = r_cycle_cnt;
  assign fail_addr = r_fail_addr;
  assign fail_data = r_fail_data;

endmodule
